muldiv_sequencer: RTL and testbench

- Iterative multi-cycle unit for the RV32M MUL/DIV/REM group, which the single-cycle ALU does not execute.
- Sits beside the ALU in the execute stage. Instructions with opcode R-type and Funct7 = 7'b0000001 are steered here.
- Stalls the pipeline through Busy while it shifts and adds, or shifts and subtracts, one bit per clock. Returns a 32-bit result with a one-cycle Done pulse.

---
 rtl/muldiv_sequencer.sv | 143 ++++++++++++++
 tb/tb_muldiv_sequencer.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/muldiv_sequencer.sv
// Iterative RV32M multiply/divide unit: one shift-add or shift-subtract step per clock,
// sign fix-up in a dedicated cycle, single-cycle Done pulse with a held Result.
module muldiv_sequencer #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            Start,
    input  logic [2:0]      Funct3,
    input  logic [XLEN-1:0] SrcA,
    input  logic [XLEN-1:0] SrcB,
    input  logic            Flush,
    output logic            Busy,
    output logic            Done,
    output logic [XLEN-1:0] Result
);
    localparam int CW = $clog2(XLEN);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t            state, state_next;
    logic [2:0]        op;
    logic              neg_a, neg_b;
    logic [XLEN-1:0]   b_mag;
    logic [CW-1:0]     count;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quot, rem;

    logic              accept, is_div, sgn_a, sgn_b, special, last_iter, div_ok;
    logic [XLEN-1:0]   a_abs, b_abs, special_val;
    logic [XLEN:0]     mul_sum, div_shift, div_diff;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quot_fix, rem_fix, fix_val;

    assign accept    = (state == IDLE) && Start && !Flush;
    assign is_div    = Funct3[2];
    assign sgn_a     = is_div ? !Funct3[0] : (Funct3[1:0] != 2'b11);
    assign sgn_b     = is_div ? !Funct3[0] : !Funct3[1];
    assign a_abs     = (sgn_a && SrcA[XLEN-1]) ? -SrcA : SrcA;
    assign b_abs     = (sgn_b && SrcB[XLEN-1]) ? -SrcB : SrcB;
    assign last_iter = (count == CW'(XLEN - 1));

    // Zero divisor and the single signed-overflow case bypass the iteration entirely.
    always_comb begin
        // NOTE: every output gets a default first, so no path can leave it unassigned and infer a latch.
        special     = 1'b0;
        special_val = '0;
        if (is_div && SrcB == '0) begin
            special     = 1'b1;
            special_val = Funct3[1] ? SrcA : '1;
        end else if (is_div && !Funct3[0] && SrcA == {1'b1, {(XLEN-1){1'b0}}} && SrcB == '1) begin
            special     = 1'b1;
            special_val = Funct3[1] ? '0 : SrcA;
        end
    end

    // Borrow out of the trial subtraction means the shifted remainder was smaller than the divisor.
    assign mul_sum   = {1'b0, prod[2*XLEN-1:XLEN]} + (prod[0] ? {1'b0, b_mag} : '0);
    assign div_shift = {rem, quot[XLEN-1]};
    assign div_diff  = div_shift - {1'b0, b_mag};
    assign div_ok    = !div_diff[XLEN];

    assign prod_fix = (neg_a ^ neg_b) ? -prod : prod;
    assign quot_fix = (neg_a ^ neg_b) ? -quot : quot;
    assign rem_fix  = neg_a ? -rem : rem;

    always_comb begin
        case (op)
            3'b000:                 fix_val = prod_fix[XLEN-1:0];
            3'b001, 3'b010, 3'b011: fix_val = prod_fix[2*XLEN-1:XLEN];
            3'b100, 3'b101:         fix_val = quot_fix;
            default:                fix_val = rem_fix;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        Busy       = 1'b0;
        Done       = 1'b0;
        case (state)
            IDLE: if (accept) state_next = special ? DONE : CALC;
            CALC: begin
                Busy = 1'b1;
                if (Flush)          state_next = IDLE;
                else if (last_iter) state_next = FIX;
            end
            FIX: begin
                Busy       = 1'b1;
                state_next = Flush ? IDLE : DONE;
            end
            DONE: begin
                Done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            op     <= '0;
            neg_a  <= 1'b0;
            neg_b  <= 1'b0;
            b_mag  <= '0;
            count  <= '0;
            prod   <= '0;
            quot   <= '0;
            rem    <= '0;
            Result <= '0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    op    <= Funct3;
                    neg_a <= sgn_a && SrcA[XLEN-1];
                    neg_b <= sgn_b && SrcB[XLEN-1];
                    b_mag <= b_abs;
                    count <= '0;
                    prod  <= {{XLEN{1'b0}}, a_abs};
                    quot  <= a_abs;
                    rem   <= '0;
                    if (special) Result <= special_val;
                end
                CALC: begin
                    count <= count + 1'b1;
                    if (op[2]) begin
                        quot <= {quot[XLEN-2:0], div_ok};
                        rem  <= div_ok ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0];
                    end else begin
                        prod <= {mul_sum, prod[XLEN-1:1]};
                    end
                end
                FIX: if (!Flush) Result <= fix_val;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed self-checking bench for muldiv_sequencer: arithmetic results, latency, Busy window,
// special cases, Flush/reset abort and ignored Start.
module tb_muldiv_sequencer;
    logic        clk = 1'b0;
    logic        reset, Start, Flush;
    logic [2:0]  Funct3;
    logic [31:0] SrcA, SrcB;
    logic        Busy, Done;
    logic [31:0] Result;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    muldiv_sequencer #(.XLEN(32)) dut (
        .clk(clk), .reset(reset), .Start(Start), .Funct3(Funct3),
        .SrcA(SrcA), .SrcB(SrcB), .Flush(Flush),
        .Busy(Busy), .Done(Done), .Result(Result)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    // Presents one op for one cycle (cycle T), then waits for Done with a bounded budget.
    // lat counts cycles from T to the Done cycle; busy_n counts Busy-high cycles before Done.
    task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          output int lat, output logic [31:0] res, output int busy_n,
                          output logic busy_at_done);
        @(negedge clk);
        Start = 1'b1; Funct3 = f3; SrcA = a; SrcB = b;
        @(negedge clk);
        Start = 1'b0;
        lat = 1; busy_n = 0;
        while (!Done && lat < 100) begin
            if (Busy) busy_n++;
            @(negedge clk);
            lat++;
        end
        res = Result;
        busy_at_done = Busy;
    endtask

    task automatic test_reset;
        reset = 1'b1; Start = 1'b0; Flush = 1'b0; Funct3 = '0; SrcA = '0; SrcB = '0;
        repeat (3) @(negedge clk);
        checks++; if (Busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", Busy); end
        checks++; if (Done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", Done); end
        checks++; if (Result !== 32'h0) begin failures++; $display("FAIL reset_result got=%h exp=00000000", Result); end
        reset = 1'b0;
    endtask

    task automatic test_mul;
        int lat, bn; logic [31:0] r; logic bd;
        run_op(3'b000, 32'd7, 32'hFFFFFFFD, lat, r, bn, bd);
        checks++; if (lat != 34) begin failures++; $display("FAIL mul_latency got=%0d exp=34", lat); end
        checks++; if (r !== 32'hFFFFFFEB) begin failures++; $display("FAIL mul_result got=%h exp=ffffffeb", r); end
        checks++; if (bn != 33) begin failures++; $display("FAIL mul_busy_cycles got=%0d exp=33", bn); end
        checks++; if (bd !== 1'b0) begin failures++; $display("FAIL mul_busy_at_done got=%b exp=0", bd); end
    endtask

    task automatic test_mul_high;
        logic [2:0]  ops [3] = '{3'b001, 3'b011, 3'b010};
        logic [31:0] exp [3] = '{32'h40000000, 32'h40000000, 32'hC0000000};
        int lat, bn; logic [31:0] r; logic bd;
        for (int i = 0; i < 3; i++) begin
            run_op(ops[i], 32'h80000000, 32'h80000000, lat, r, bn, bd);
            checks++; if (r !== exp[i]) begin failures++; $display("FAIL mulh_f3_%0d got=%h exp=%h", ops[i], r, exp[i]); end
            checks++; if (lat != 34) begin failures++; $display("FAIL mulh_lat_f3_%0d got=%0d exp=34", ops[i], lat); end
        end
    endtask

    task automatic test_div;
        logic [2:0]  ops [4] = '{3'b100, 3'b110, 3'b101, 3'b111};
        logic [31:0] exp [4] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'h7FFFFFFC, 32'h00000001};
        int lat, bn; logic [31:0] r; logic bd;
        for (int i = 0; i < 4; i++) begin
            run_op(ops[i], 32'hFFFFFFF9, 32'd2, lat, r, bn, bd);
            checks++; if (r !== exp[i]) begin failures++; $display("FAIL div_f3_%0d got=%h exp=%h", ops[i], r, exp[i]); end
            checks++; if (lat != 34) begin failures++; $display("FAIL div_lat_f3_%0d got=%0d exp=34", ops[i], lat); end
        end
        run_op(3'b101, 32'd100, 32'd7, lat, r, bn, bd);
        checks++; if (r !== 32'd14) begin failures++; $display("FAIL divu_100_7 got=%h exp=0000000e", r); end
    endtask

    task automatic test_special;
        logic [2:0]  ops [4] = '{3'b100, 3'b111, 3'b100, 3'b110};
        logic [31:0] as  [4] = '{32'd5, 32'd5, 32'h80000000, 32'h80000000};
        logic [31:0] bs  [4] = '{32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF};
        logic [31:0] exp [4] = '{32'hFFFFFFFF, 32'd5, 32'h80000000, 32'h0};
        int lat, bn; logic [31:0] r; logic bd;
        for (int i = 0; i < 4; i++) begin
            run_op(ops[i], as[i], bs[i], lat, r, bn, bd);
            checks++; if (r !== exp[i]) begin failures++; $display("FAIL special_%0d got=%h exp=%h", i, r, exp[i]); end
            checks++; if (lat != 1) begin failures++; $display("FAIL special_lat_%0d got=%0d exp=1", i, lat); end
        end
    endtask

    // Second Start during CALC is ignored; Start held through the Done cycle is not accepted there.
    task automatic test_ignore_start;
        int lat = 1;
        logic [31:0] r;
        @(negedge clk);
        Start = 1'b1; Funct3 = 3'b000; SrcA = 32'd7; SrcB = 32'hFFFFFFFD;
        @(negedge clk);
        Start = 1'b0;
        while (!Done && lat < 100) begin
            if (lat == 5) begin Start = 1'b1; Funct3 = 3'b001; SrcA = 32'd2; SrcB = 32'd3; end
            @(negedge clk);
            lat++;
        end
        r = Result;
        checks++; if (lat != 34) begin failures++; $display("FAIL ignore_latency got=%0d exp=34", lat); end
        checks++; if (r !== 32'hFFFFFFEB) begin failures++; $display("FAIL ignore_result got=%h exp=ffffffeb", r); end
        @(negedge clk);
        checks++; if (Busy !== 1'b0) begin failures++; $display("FAIL start_in_done_busy got=%b exp=0", Busy); end
        Start = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_flush;
        int n = 0;
        logic [31:0] prior = Result;
        @(negedge clk);
        Start = 1'b1; Funct3 = 3'b000; SrcA = 32'd3; SrcB = 32'd5;
        @(negedge clk);
        Start = 1'b0;
        repeat (9) @(negedge clk);
        Flush = 1'b1;
        @(negedge clk);
        Flush = 1'b0;
        checks++; if (Busy !== 1'b0) begin failures++; $display("FAIL flush_busy got=%b exp=0", Busy); end
        repeat (40) begin @(negedge clk); if (Done) n++; end
        checks++; if (n != 0) begin failures++; $display("FAIL flush_done_count got=%0d exp=0", n); end
        checks++; if (Result !== prior) begin failures++; $display("FAIL flush_result got=%h exp=%h", Result, prior); end
    endtask

    task automatic test_flush_with_start;
        int n = 0, b = 0;
        @(negedge clk);
        Start = 1'b1; Flush = 1'b1; Funct3 = 3'b100; SrcA = 32'd5; SrcB = 32'd0;
        @(negedge clk);
        Start = 1'b0; Flush = 1'b0;
        repeat (40) begin if (Done) n++; if (Busy) b++; @(negedge clk); end
        checks++; if (n != 0) begin failures++; $display("FAIL flush_start_done got=%0d exp=0", n); end
        checks++; if (b != 0) begin failures++; $display("FAIL flush_start_busy got=%0d exp=0", b); end
    endtask

    task automatic test_reset_mid;
        int n = 0;
        @(negedge clk);
        Start = 1'b1; Funct3 = 3'b000; SrcA = 32'd9; SrcB = 32'd9;
        @(negedge clk);
        Start = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++; if (Busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy got=%b exp=0", Busy); end
        checks++; if (Done !== 1'b0) begin failures++; $display("FAIL rstmid_done got=%b exp=0", Done); end
        checks++; if (Result !== 32'h0) begin failures++; $display("FAIL rstmid_result got=%h exp=00000000", Result); end
        repeat (40) begin @(negedge clk); if (Done) n++; end
        checks++; if (n != 0) begin failures++; $display("FAIL rstmid_done_count got=%0d exp=0", n); end
    endtask

    initial begin
        test_reset();
        test_mul();
        test_mul_high();
        test_div();
        test_special();
        test_ignore_start();
        test_flush();
        test_flush_with_start();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
